// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
package nibble_serial_adder_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Request/response handshake bundle between the ALU front-end and the sequencer.
interface nibble_serial_adder_ctrl_if
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
);
  localparam int WIDTH = NIBBLE_W * NIBBLES;

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             req_cin;
  logic             req_sub;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_sum;
  logic             rsp_cout;
  logic             rsp_ovf;

  modport master (
    output req_valid, req_a, req_b, req_cin, req_sub, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_ovf
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, req_sub, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_ovf
  );

endinterface

// File: rtl/nibble_serial_adder_ctrl_cell.sv
// Existing 4-bit ripple-carry adder cell, shared by every nibble of an operation.
module nibble_serial_adder_ctrl_cell
  import nibble_serial_adder_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);

  logic [NIBBLE_W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[NIBBLE_W];
  end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Sequences a WIDTH-bit add/subtract through one 4-bit adder cell, LS nibble first.
// state   | meaning
// IDLE    | ready for a request
// ADD     | one nibble per clock through the shared cell
// RESP    | result presented, waiting for rsp_ready
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int WIDTH   = NIBBLE_W * NIBBLES
)(
  input  logic                       clk,
  input  logic                       rst_n,
  nibble_serial_adder_ctrl_if.slave  bus,
  output logic                       busy
);

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_reg, b_reg, sum_reg, sum_nxt;
  logic               carry;
  logic [IDX_W-1:0]   idx;
  logic [NIBBLE_W-1:0] cell_s;
  logic               cell_cout;
  logic               last;

  nibble_serial_adder_ctrl_cell u_cell (
    .a    (a_reg[NIBBLE_W-1:0]),
    .b    (b_reg[NIBBLE_W-1:0]),
    .cin  (carry),
    .s    (cell_s),
    .cout (cell_cout)
  );

  assign last    = (idx == IDX_W'(NIBBLES - 1));
  // New nibble enters at the top so the sum lands aligned after NIBBLES shifts.
  assign sum_nxt = (sum_reg >> NIBBLE_W) | (WIDTH'(cell_s) << (WIDTH - NIBBLE_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    busy          = 1'b1;
    case (state)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        busy          = 1'b0;
        if (bus.req_valid) state_nxt = ST_ADD;
      end
      ST_ADD: begin
        if (last) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg        <= '0;
      b_reg        <= '0;
      sum_reg      <= '0;
      carry        <= 1'b0;
      idx          <= '0;
      bus.rsp_sum  <= '0;
      bus.rsp_cout <= 1'b0;
      bus.rsp_ovf  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            a_reg <= bus.req_a;
            b_reg <= bus.req_sub ? ~bus.req_b : bus.req_b;
            carry <= bus.req_cin ^ bus.req_sub;
            idx   <= '0;
          end
        end
        ST_ADD: begin
          a_reg   <= a_reg >> NIBBLE_W;
          b_reg   <= b_reg >> NIBBLE_W;
          sum_reg <= sum_nxt;
          carry   <= cell_cout;
          idx     <= idx + 1'b1;
          if (last) begin
            bus.rsp_sum  <= sum_nxt;
            bus.rsp_cout <= cell_cout;
            bus.rsp_ovf  <= (a_reg[NIBBLE_W-1] == b_reg[NIBBLE_W-1]) &
                            (cell_s[NIBBLE_W-1] != a_reg[NIBBLE_W-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
